// File: rtl/gemm_cmd_pkg.sv
// Shared types and defaults for the GEMM command dispatch path.
// State encodings are fixed so existing CSR debug decoders keep working.
package gemm_cmd_pkg;

    localparam int unsigned CMD_WIDTH_DEF = 32;
    localparam int unsigned NUM_WORDS_DEF = 4;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ISSUE       = 2'd1;
    localparam logic [1:0] ST_WAIT_CREDIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE        = ST_IDLE,
        ISSUE       = ST_ISSUE,
        WAIT_CREDIT = ST_WAIT_CREDIT
    } dispatch_state_t;

    typedef logic [NUM_WORDS_DEF-1:0][CMD_WIDTH_DEF-1:0] cmd_t;

endpackage

// File: rtl/gemm_cmd_fifo.sv
// Synchronous command FIFO with registered read-on-pop; a push is accepted
// while full when a pop frees the slot in the same cycle.
module gemm_cmd_fifo
    import gemm_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = CMD_WIDTH_DEF * NUM_WORDS_DEF,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rdata_d  = mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is not reset; only slots behind valid pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/gemm_cmd_dispatcher.sv
// Queues CSR command snapshots and issues them to the GEMM engine with an
// in-flight credit limit; exposes submit/done counters and sticky errors.
module gemm_cmd_dispatcher
    import gemm_cmd_pkg::*;
#(
    parameter int unsigned CMD_WIDTH    = CMD_WIDTH_DEF,
    parameter int unsigned NUM_WORDS    = NUM_WORDS_DEF,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_submit_pulse,
    input  logic [NUM_WORDS*CMD_WIDTH-1:0]  i_cmd_words,
    input  logic                            i_flush,
    output logic                            o_cmd_valid,
    input  logic                            i_cmd_ready,
    output logic [NUM_WORDS*CMD_WIDTH-1:0]  o_cmd_data,
    input  logic                            i_cmd_done,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
    output logic [3:0]                      o_inflight,
    output logic [15:0]                     o_submit_count,
    output logic [15:0]                     o_done_count,
    output logic                            o_overflow,
    output logic                            o_done_err,
    output logic                            o_busy
);

    localparam int unsigned DW      = NUM_WORDS * CMD_WIDTH;
    localparam logic [3:0]  MAX_INF = 4'(MAX_INFLIGHT);

    dispatch_state_t state_q, state_d;
    logic            valid_q, valid_d;
    logic [3:0]      inflight_q, inflight_d;
    logic [15:0]     sub_cnt_q, sub_cnt_d;
    logic [15:0]     done_cnt_q, done_cnt_d;
    logic            ovf_q, ovf_d;
    logic            derr_q, derr_d;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [DW-1:0]               fifo_rdata;
    logic                        pop;
    logic                        push_ok;
    logic                        credit_ok;
    logic                        handshake;
    logic                        done_ok;

    assign credit_ok = (inflight_q < MAX_INF);
    assign handshake = valid_q && i_cmd_ready;
    assign done_ok   = i_cmd_done && (inflight_q != '0);
    // A full FIFO still accepts a submit when the FSM pops in the same cycle.
    assign push_ok   = i_submit_pulse && !i_flush && (!fifo_full || pop);

    gemm_cmd_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push_i    (push_ok),
        .wdata_i   (i_cmd_words),
        .pop_i     (pop),
        .flush_i   (i_flush),
        .rdata_o   (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !i_flush) begin
                    if (credit_ok) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = WAIT_CREDIT;
                    end
                end
            end
            WAIT_CREDIT: begin
                if (i_flush || fifo_empty) begin
                    state_d = IDLE;
                end else if (credit_ok) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (i_cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = (state_d == ISSUE);
        inflight_d = inflight_q;
        case ({handshake, done_ok})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
        // Submits coincident with a flush are discarded but still counted.
        sub_cnt_d  = sub_cnt_q;
        if (i_submit_pulse && (i_flush || push_ok)) begin
            sub_cnt_d = sub_cnt_q + 16'd1;
        end
        done_cnt_d = done_cnt_q;
        if (done_ok) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
        ovf_d  = ovf_q  | (i_submit_pulse && !i_flush && !push_ok);
        derr_d = derr_q | (i_cmd_done && (inflight_q == '0));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            inflight_q <= '0;
            sub_cnt_q  <= '0;
            done_cnt_q <= '0;
            ovf_q      <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            sub_cnt_q  <= sub_cnt_d;
            done_cnt_q <= done_cnt_d;
            ovf_q      <= ovf_d;
            derr_q     <= derr_d;
        end
    end

    assign o_cmd_valid    = valid_q;
    assign o_cmd_data     = fifo_rdata;
    assign o_fifo_count   = fifo_count;
    assign o_inflight     = inflight_q;
    assign o_submit_count = sub_cnt_q;
    assign o_done_count   = done_cnt_q;
    assign o_overflow     = ovf_q;
    assign o_done_err     = derr_q;
    assign o_busy         = !fifo_empty || valid_q || (inflight_q != '0);

endmodule

// File: tb/tb_gemm_cmd_dispatcher.sv
// Directed and random stimulus for gemm_cmd_dispatcher, checked each cycle
// against a queue-based reference model of the dispatch rules.
module tb_gemm_cmd_dispatcher;

    localparam int CW    = 32;
    localparam int NW    = 4;
    localparam int DEPTH = 8;
    localparam int MAXI  = 2;
    localparam int DW    = CW * NW;
    localparam int FCW   = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sub = 1'b0;
    logic [DW-1:0]  words = '0;
    logic           fl = 1'b0;
    logic           rdy = 1'b0;
    logic           dn = 1'b0;

    logic           o_cmd_valid;
    logic [DW-1:0]  o_cmd_data;
    logic [FCW-1:0] o_fifo_count;
    logic [3:0]     o_inflight;
    logic [15:0]    o_submit_count;
    logic [15:0]    o_done_count;
    logic           o_overflow;
    logic           o_done_err;
    logic           o_busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_inflight;
    int            m_sub;
    int            m_done;
    bit            m_ovf;
    bit            m_derr;

    logic [DW-1:0] wa, wb;

    gemm_cmd_dispatcher #(
        .CMD_WIDTH    (CW),
        .NUM_WORDS    (NW),
        .FIFO_DEPTH   (DEPTH),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_submit_pulse (sub),
        .i_cmd_words    (words),
        .i_flush        (fl),
        .o_cmd_valid    (o_cmd_valid),
        .i_cmd_ready    (rdy),
        .o_cmd_data     (o_cmd_data),
        .i_cmd_done     (dn),
        .o_fifo_count   (o_fifo_count),
        .o_inflight     (o_inflight),
        .o_submit_count (o_submit_count),
        .o_done_count   (o_done_count),
        .o_overflow     (o_overflow),
        .o_done_err     (o_done_err),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_cmd();
        logic [DW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*CW +: CW] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_valid = 0; m_data = '0; m_inflight = 0;
        m_sub = 0; m_done = 0; m_ovf = 0; m_derr = 0;
    endtask

    // One clock edge of the dispatch rules, evaluated on pre-edge state.
    task automatic model_edge(input bit s, input logic [DW-1:0] w, input bit f,
                              input bit rd, input bit d);
        int  infl0 = m_inflight;
        int  sz0   = m_q.size();
        bit  popped = 0;
        int  delta  = 0;
        if (m_valid) begin
            if (rd) begin
                m_valid = 0;
                delta++;
            end
        end else if (sz0 > 0 && infl0 < MAXI && !f) begin
            popped  = 1;
            m_data  = m_q.pop_front();
            m_valid = 1;
        end
        if (f) m_q.delete();
        if (s) begin
            if (f) m_sub = (m_sub + 1) % 65536;
            else if (sz0 < DEPTH || popped) begin
                m_q.push_back(w);
                m_sub = (m_sub + 1) % 65536;
            end else m_ovf = 1;
        end
        if (d) begin
            if (infl0 == 0) m_derr = 1;
            else begin
                m_done = (m_done + 1) % 65536;
                delta--;
            end
        end
        m_inflight = infl0 + delta;
    endtask

    task automatic check_all();
        chk("cmd_valid",    DW'(o_cmd_valid),    DW'(m_valid));
        chk("cmd_data",     o_cmd_data,          m_data);
        chk("fifo_count",   DW'(o_fifo_count),   DW'(m_q.size()));
        chk("inflight",     DW'(o_inflight),     DW'(m_inflight));
        chk("submit_count", DW'(o_submit_count), DW'(m_sub));
        chk("done_count",   DW'(o_done_count),   DW'(m_done));
        chk("overflow",     DW'(o_overflow),     DW'(m_ovf));
        chk("done_err",     DW'(o_done_err),     DW'(m_derr));
        chk("busy",         DW'(o_busy),
            DW'(m_q.size() != 0 || m_valid || m_inflight != 0));
    endtask

    task automatic step(input bit r, input bit s, input logic [DW-1:0] w,
                        input bit f, input bit rd, input bit d);
        rst_n = !r; sub = s; words = w; fl = f; rdy = rd; dn = d;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(s, w, f, rd, d);
        #1;
        check_all();
        rst_n = 1'b1; sub = 1'b0; fl = 1'b0; dn = 1'b0;
    endtask

    initial begin
        model_reset();
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        chk("reset_valid", DW'(o_cmd_valid), '0);
        chk("reset_data",  o_cmd_data,       '0);

        // Single command, ready high throughout
        wa = {32'h4, 32'h3, 32'h2, 32'h1};
        step(0, 1, wa, 0, 1, 0);
        chk("t1_count_after_submit", DW'(o_fifo_count), DW'(1));
        step(0, 0, '0, 0, 1, 0);
        chk("t1_valid", DW'(o_cmd_valid), DW'(1));
        chk("t1_data",  o_cmd_data,       wa);
        step(0, 0, '0, 0, 1, 0);
        chk("t1_valid_one_cycle", DW'(o_cmd_valid), DW'(0));
        chk("t1_inflight",        DW'(o_inflight),  DW'(1));
        step(0, 0, '0, 0, 0, 1);
        chk("t1_done_count", DW'(o_done_count), DW'(1));
        chk("t1_busy",       DW'(o_busy),       DW'(0));

        // Three commands against a credit limit of two
        for (int i = 0; i < 3; i++) begin
            step(0, 1, rnd_cmd(), 0, 1, 0);
            step(0, 0, '0, 0, 1, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1, 0);
        chk("t2_fifo_waiting", DW'(o_fifo_count), DW'(1));
        chk("t2_inflight_max", DW'(o_inflight),   DW'(2));
        chk("t2_no_issue",     DW'(o_cmd_valid),  DW'(0));
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0);
        chk("t2_credit_issue", DW'(o_cmd_valid), DW'(1));
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);

        // Fill while the engine stalls, then overflow
        step(1, 0, '0, 0, 0, 0);
        wb = rnd_cmd();
        step(0, 1, wb, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, rnd_cmd(), 0, 0, 0);
            step(0, 0, '0, 0, 0, 0);
        end
        chk("t3_full",      DW'(o_fifo_count),   DW'(8));
        chk("t3_sub_count", DW'(o_submit_count), DW'(9));
        chk("t3_no_ovf",    DW'(o_overflow),     DW'(0));
        step(0, 1, rnd_cmd(), 0, 0, 0);
        chk("t3_ovf",       DW'(o_overflow),     DW'(1));
        chk("t3_sub_held",  DW'(o_submit_count), DW'(9));

        // Flush under a stalled issue
        step(0, 0, '0, 1, 0, 0);
        chk("t4_flushed",    DW'(o_fifo_count), DW'(0));
        chk("t4_valid_hold", DW'(o_cmd_valid),  DW'(1));
        chk("t4_data_hold",  o_cmd_data,        wb);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 0, 0);
        chk("t4_busy_inflight", DW'(o_busy), DW'(1));
        step(0, 0, '0, 0, 0, 1);
        chk("t4_idle", DW'(o_busy), DW'(0));

        // Spurious done, then handshake coincident with done
        step(0, 0, '0, 0, 0, 1);
        chk("t5_done_err",  DW'(o_done_err),   DW'(1));
        chk("t5_done_cnt",  DW'(o_done_count), DW'(1));
        step(0, 1, rnd_cmd(), 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 1, rnd_cmd(), 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 1, 1);
        chk("t5_inflight_same", DW'(o_inflight), DW'(1));

        // Reset while issuing with commands queued
        for (int i = 0; i < 3; i++) begin
            step(0, 1, rnd_cmd(), 0, 0, 0);
            step(0, 0, '0, 0, 0, 0);
        end
        step(1, 0, '0, 0, 0, 0);
        chk("t6_valid", DW'(o_cmd_valid),    '0);
        chk("t6_count", DW'(o_fifo_count),   '0);
        chk("t6_sub",   DW'(o_submit_count), '0);
        chk("t6_err",   DW'(o_done_err),     '0);

        // Random traffic
        begin
            bit ps = 0;
            bit pd = 0;
            for (int i = 0; i < 500; i++) begin
                bit s, f, rd, d;
                s  = !ps && ($urandom_range(0, 2) == 0);
                f  = ($urandom_range(0, 59) == 0);
                rd = ($urandom_range(0, 1) == 0);
                if (m_inflight > 0) d = !pd && ($urandom_range(0, 2) == 0);
                else                d = ($urandom_range(0, 99) == 0);
                step(0, s, rnd_cmd(), f, rd, d);
                ps = s;
                pd = d;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemm_cmd_dispatcher.md
# gemm_cmd_dispatcher

Command dispatch controller between the CSR command-submit path and the GEMM engine command port. Each single-cycle submit pulse captures the multi-word CSR command snapshot into an internal FIFO. Queued commands are issued to the engine over a valid/ready handshake, with the number of in-flight commands throttled. Submission and completion counters and sticky error flags are exposed back to CSRs.

## Interface
- CMD_WIDTH, 32, width of one CSR command word
- NUM_WORDS, 4, command words per command
- FIFO_DEPTH, 8, queued command capacity (power of two, ≥2)
- MAX_INFLIGHT, 2, maximum issued-but-not-completed commands (1..15)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_submit_pulse  in  1  one-cycle pulse per CSR submit write (rising-edge derived)
- i_cmd_words  in  NUM_WORDS*CMD_WIDTH  CSR command snapshot; word 0 in LSBs
- i_flush  in  1  one-cycle request to discard all queued (not issued) commands
- o_cmd_valid  out  1  command offered to engine
- i_cmd_ready  in  1  engine accepts command
- o_cmd_data  out  NUM_WORDS*CMD_WIDTH  command payload
- i_cmd_done  in  1  one-cycle completion pulse from engine
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  queued commands
- o_inflight  out  4  issued, uncompleted commands
- o_submit_count  out  16  accepted submits, wraps modulo 2^16
- o_done_count  out  16  completions, wraps modulo 2^16
- o_overflow  out  1  sticky: submit dropped because FIFO full
- o_done_err  out  1  sticky: i_cmd_done received while o_inflight==0
- o_busy  out  1  FIFO non-empty, or o_cmd_valid, or o_inflight≠0

## Operation
- Reset: all counters 0, FIFO empty, state IDLE, o_cmd_valid 0, o_cmd_data 0, sticky flags 0.
- Capture: on i_submit_pulse, i_cmd_words is written to the FIFO and o_submit_count increments. If the FIFO is full, the command is dropped, o_overflow is set, and the count does not increment.
- A submit and a pop in the same cycle with the FIFO full: the pop frees the slot and the submit is accepted.
- FSM states:
  - IDLE: if FIFO non-empty and o_inflight<MAX_INFLIGHT, pop the head into the o_cmd_data register and go to ISSUE. If FIFO non-empty and at the limit, go to WAIT_CREDIT.
  - WAIT_CREDIT: when o_inflight<MAX_INFLIGHT, pop and go to ISSUE.
  - ISSUE: o_cmd_valid=1; o_cmd_data stable. On i_cmd_ready, go to IDLE.
- o_cmd_valid is never withdrawn before handshake; flush and overflow do not affect ISSUE.
- Inflight accounting:
  - Handshake (valid&ready) increments o_inflight; i_cmd_done decrements it.
  - Both in the same cycle: unchanged.
  - i_cmd_done with o_inflight==0: ignored, o_done_err set, o_done_count unchanged.
  - Otherwise each i_cmd_done increments o_done_count.
- Flush: empties the FIFO in the cycle after i_flush. WAIT_CREDIT returns to IDLE. An in-progress ISSUE completes normally.
  - i_submit_pulse coincident with i_flush: the command is discarded but still counted in o_submit_count.
- Sticky flags clear only on reset.

## Timing
- Submit pulse at edge E0 → FIFO count 1 after E0 → pop at E1 → o_cmd_valid=1 from E1 when idle with credit (1-cycle capture-to-issue latency).
- Back-to-back: the next o_cmd_valid can assert the cycle after a handshake (one IDLE cycle between issues); peak rate is one command per 2 cycles.
- Credit return: i_cmd_done at edge Ed in WAIT_CREDIT → pop at Ed+1 → o_cmd_valid from Ed+1.
- All outputs are registered except o_busy (combinational from registers).

## Structure
- Shared package gemm_cmd_pkg:
  - dispatch_state_t enum (IDLE, ISSUE, WAIT_CREDIT)
  - CMD_WIDTH/NUM_WORDS defaults
  - cmd_t packed-array typedef for one command
- Sub-module gemm_cmd_fifo: synchronous FIFO with push/pop/full/empty/count, registered read on pop, same-cycle push+pop when full permitted.
- FSM, inflight counter, status counters and flags live in the top level.

## Test plan
- Single submit of words {0x1,0x2,0x3,0x4}, i_cmd_ready=1 → o_cmd_valid for exactly 1 cycle, o_cmd_data matches, o_inflight=1; then i_cmd_done → o_inflight=0, o_done_count=1, o_busy=0.
- 3 submits, MAX_INFLIGHT=2, no done → two issues, state WAIT_CREDIT, o_fifo_count=1; one i_cmd_done → third issues within 1 cycle.
- 9 submits with i_cmd_ready=0 → FIFO holds 8, 1 popped into ISSUE; then FIFO full so the 10th submit sets o_overflow, o_submit_count=9 after 9 accepted.
- Hold i_cmd_ready=0 in ISSUE while pulsing i_flush with 3 queued → o_cmd_valid and o_cmd_data hold; FIFO count 0; after ready, o_busy follows inflight only.
- i_cmd_done with o_inflight=0 → o_done_err=1, counts unchanged; handshake coincident with done at inflight=1 → inflight stays 1.
- Assert reset while in ISSUE with FIFO non-empty → all outputs return to reset values the next cycle.
